// File: rtl/sseg_pkg.sv
// rtl/sseg_pkg.sv - shared seven-segment types, glyph constants and FSM state encoding
`timescale 1ns/1ps
package sseg_pkg;

  // Segment pattern, active-low: bit7 = dp, bits 6:0 = g,f,e,d,c,b,a
  typedef logic [7:0] sseg_t;

  localparam logic [6:0] SSEG_BLANK = 7'h7F;
  localparam logic [6:0] SSEG_DASH  = 7'h3F;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    ENC  = 2'd2
  } fmt_state_t;

  // Hex nibble to active-low g..a glyph
  function automatic logic [6:0] hex_to_sseg(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      default: seg = 7'h0E;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/sseg_num_fmt.sv
// rtl/sseg_num_fmt.sv - binary to eight seven-segment patterns, hex or decimal (double-dabble)
`timescale 1ns/1ps
module sseg_num_fmt
  import sseg_pkg::*;
#(
  parameter int W = 27
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [W-1:0] bin,
  input  logic         dec_mode,
  input  logic         blank_lz,
  input  logic [7:0]   dp,
  output logic         ready,
  output logic         done_tick,
  output logic         overflow,
  output sseg_t        sseg0,
  output sseg_t        sseg1,
  output sseg_t        sseg2,
  output sseg_t        sseg3,
  output sseg_t        sseg4,
  output sseg_t        sseg5,
  output sseg_t        sseg6,
  output sseg_t        sseg7
);

  fmt_state_t   state_q;
  logic [W-1:0] bin_q;
  logic         dec_q;
  logic         blank_q;
  logic [7:0]   dp_q;
  logic [31:0]  bcd_q;
  logic [W-1:0] sh_q;
  logic [5:0]   cnt_q;
  logic         done_q;
  logic         ovf_q;
  sseg_t        sseg_q [8];
  sseg_t        sseg_d [8];

  logic [31:0]   bcd_adj;
  logic [W+31:0] dd_wide;
  logic [W+31:0] dd_next;
  logic [31:0]   bin_pad;
  logic [31:0]   digits;
  logic          ovf_w;
  logic [2:0]    msd;

  // Double-dabble correction: every BCD nibble >= 5 gets +3 before the shift
  always_comb begin
    bcd_adj = '0;
    for (int j = 0; j < 8; j++) begin
      bcd_adj[4*j +: 4] = (bcd_q[4*j +: 4] >= 4'd5) ? bcd_q[4*j +: 4] + 4'd3 : bcd_q[4*j +: 4];
    end
  end

  assign dd_wide = {bcd_adj, sh_q};
  assign dd_next = dd_wide << 1;

  assign bin_pad = 32'(bin_q);
  assign digits  = dec_q ? bcd_q : bin_pad;
  // BCD only holds 8 digits, so anything from 100_000_000 up is shown as dashes
  assign ovf_w   = dec_q && ({1'b0, bin_pad} >= 33'd100_000_000);

  // Encode digits to glyphs with leading-zero blanking, dash override and decimal points
  always_comb begin
    msd = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (digits[4*i +: 4] != 4'd0) msd = 3'(i);
    end
    for (int i = 0; i < 8; i++) begin
      sseg_d[i] = {~dp_q[i], hex_to_sseg(digits[4*i +: 4])};
      if (blank_q && (3'(i) > msd)) sseg_d[i][6:0] = SSEG_BLANK;
      if (ovf_w) sseg_d[i][6:0] = SSEG_DASH;
    end
  end

  // Control FSM with conversion datapath; outputs only change in ENC so they never flicker
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      bin_q   <= '0;
      dec_q   <= 1'b0;
      blank_q <= 1'b0;
      dp_q    <= '0;
      bcd_q   <= '0;
      sh_q    <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
      for (int i = 0; i < 8; i++) sseg_q[i] <= 8'hFF;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            bin_q   <= bin;
            dec_q   <= dec_mode;
            blank_q <= blank_lz;
            dp_q    <= dp;
            ovf_q   <= 1'b0;
            if (dec_mode) begin
              bcd_q   <= '0;
              sh_q    <= bin;
              cnt_q   <= 6'(W - 1);
              state_q <= CONV;
            end else begin
              state_q <= ENC;
            end
          end
        end
        CONV: begin
          bcd_q <= dd_next[W+31:W];
          sh_q  <= dd_next[W-1:0];
          if (cnt_q == 6'd0) state_q <= ENC;
          else cnt_q <= cnt_q - 6'd1;
        end
        ENC: begin
          for (int i = 0; i < 8; i++) sseg_q[i] <= sseg_d[i];
          ovf_q   <= ovf_w;
          done_q  <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ready     = (state_q == IDLE);
  assign done_tick = done_q;
  assign overflow  = ovf_q;
  assign sseg0     = sseg_q[0];
  assign sseg1     = sseg_q[1];
  assign sseg2     = sseg_q[2];
  assign sseg3     = sseg_q[3];
  assign sseg4     = sseg_q[4];
  assign sseg5     = sseg_q[5];
  assign sseg6     = sseg_q[6];
  assign sseg7     = sseg_q[7];

endmodule

// File: tb/tb_sseg_num_fmt.sv
// tb/tb_sseg_num_fmt.sv - self-checking bench for sseg_num_fmt against an arithmetic reference model
`timescale 1ns/1ps
module tb_sseg_num_fmt;

  localparam int W = 27;
  localparam logic [6:0] GLYPH [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] bin = '0;
  logic         dec_mode = 1'b0;
  logic         blank_lz = 1'b0;
  logic [7:0]   dp = '0;
  logic         ready, done_tick, overflow;
  logic [7:0]   s0, s1, s2, s3, s4, s5, s6, s7;
  logic [63:0]  segs;

  int n_pass = 0;
  int n_total = 0;

  assign segs = {s7, s6, s5, s4, s3, s2, s1, s0};

  sseg_num_fmt #(.W(W)) dut (
    .clk(clk), .reset(reset), .start(start), .bin(bin), .dec_mode(dec_mode),
    .blank_lz(blank_lz), .dp(dp), .ready(ready), .done_tick(done_tick), .overflow(overflow),
    .sseg0(s0), .sseg1(s1), .sseg2(s2), .sseg3(s3),
    .sseg4(s4), .sseg5(s5), .sseg6(s6), .sseg7(s7)
  );

  always #5 clk = ~clk;

  // Reference: digits by division or nibble extraction, then glyph, blanking, dashes, dp
  function automatic void ref_model(input longint unsigned v, input bit dec, input bit blank,
                                    input logic [7:0] dpv, output logic [63:0] exp_segs,
                                    output logic exp_ovf);
    int dig [8];
    int msd;
    longint unsigned p;
    logic [6:0] g;
    exp_ovf = dec && (v >= 100000000);
    p = 1;
    for (int i = 0; i < 8; i++) begin
      dig[i] = dec ? int'((v / p) % 10) : int'((v >> (4 * i)) & 15);
      p = p * 10;
    end
    msd = 0;
    for (int i = 0; i < 8; i++) if (dig[i] != 0) msd = i;
    for (int i = 0; i < 8; i++) begin
      if (exp_ovf) g = 7'h3F;
      else if (blank && i > msd) g = 7'h7F;
      else g = GLYPH[dig[i]];
      exp_segs[8*i +: 8] = {~dpv[i], g};
    end
  endfunction

  // Accept one operand and count posedges until done_tick; lat = -1 on timeout
  task automatic run_conv(input logic [W-1:0] v, input bit dec, input bit blank,
                          input logic [7:0] dpv, output int lat, output int ready_bad);
    int n;
    @(negedge clk);
    bin = v; dec_mode = dec; blank_lz = blank; dp = dpv; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    ready_bad = ready ? 1 : 0;
    n = 0;
    lat = -1;
    while (n < 100) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (done_tick) begin
        lat = n;
        break;
      end
      if (ready) ready_bad++;
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    n_total++; if (ready !== 1'b1) $display("FAIL reset_ready: got %b expected 1", ready); else n_pass++;
    n_total++; if (done_tick !== 1'b0) $display("FAIL reset_done: got %b expected 0", done_tick); else n_pass++;
    n_total++; if (overflow !== 1'b0) $display("FAIL reset_ovf: got %b expected 0", overflow); else n_pass++;
    n_total++; if (segs !== {8{8'hFF}}) $display("FAIL reset_segs: got %h expected %h", segs, {8{8'hFF}}); else n_pass++;
  endtask

  task automatic test_dec_1234();
    int lat, rb;
    logic [63:0] es;
    logic eo;
    run_conv(27'd1234, 1'b1, 1'b1, 8'h00, lat, rb);
    ref_model(1234, 1'b1, 1'b1, 8'h00, es, eo);
    n_total++; if (lat !== 28) $display("FAIL dec1234_latency: got %0d expected 28", lat); else n_pass++;
    n_total++; if (rb !== 0) $display("FAIL dec1234_ready_low: got %0d ready-high cycles expected 0", rb); else n_pass++;
    n_total++; if (segs !== es) $display("FAIL dec1234_model: got %h expected %h", segs, es); else n_pass++;
    n_total++; if (segs !== 64'hFFFF_FFFF_F9A4_B099) $display("FAIL dec1234_const: got %h expected %h", segs, 64'hFFFF_FFFF_F9A4_B099); else n_pass++;
  endtask

  task automatic test_hex();
    int lat, rb;
    logic [63:0] es;
    logic eo;
    run_conv(27'h00A000F, 1'b0, 1'b0, 8'h00, lat, rb);
    ref_model(64'h00A000F, 1'b0, 1'b0, 8'h00, es, eo);
    n_total++; if (lat !== 1) $display("FAIL hex_latency: got %0d expected 1", lat); else n_pass++;
    n_total++; if (segs !== es) $display("FAIL hex_model: got %h expected %h", segs, es); else n_pass++;
    n_total++; if (segs !== 64'hC0C0_C088_C0C0_C08E) $display("FAIL hex_const: got %h expected %h", segs, 64'hC0C0_C088_C0C0_C08E); else n_pass++;
  endtask

  task automatic test_overflow();
    int lat, rb;
    run_conv(27'd100_000_000, 1'b1, 1'b0, 8'h00, lat, rb);
    n_total++; if (segs !== {8{8'hBF}}) $display("FAIL ovf_segs: got %h expected %h", segs, {8{8'hBF}}); else n_pass++;
    n_total++; if (overflow !== 1'b1) $display("FAIL ovf_flag: got %b expected 1", overflow); else n_pass++;
    run_conv(27'd0, 1'b1, 1'b1, 8'h00, lat, rb);
    n_total++; if (segs !== 64'hFFFF_FFFF_FFFF_FFC0) $display("FAIL zero_segs: got %h expected %h", segs, 64'hFFFF_FFFF_FFFF_FFC0); else n_pass++;
    n_total++; if (overflow !== 1'b0) $display("FAIL zero_ovf: got %b expected 0", overflow); else n_pass++;
  endtask

  task automatic test_dp();
    int lat, rb;
    run_conv(27'd5, 1'b1, 1'b1, 8'h04, lat, rb);
    n_total++; if (segs !== 64'hFFFF_FFFF_FF7F_FF92) $display("FAIL dp_segs: got %h expected %h", segs, 64'hFFFF_FFFF_FF7F_FF92); else n_pass++;
  endtask

  task automatic test_busy_ignore();
    int n, dones, first;
    logic [63:0] es;
    logic eo;
    @(negedge clk);
    bin = 27'd4321; dec_mode = 1'b1; blank_lz = 1'b0; dp = 8'h81; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    dones = 0; first = -1;
    for (n = 1; n <= 60; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (done_tick) begin
        dones++;
        if (first < 0) first = n;
      end
      if (n == 5) begin bin = 27'd999; dec_mode = 1'b0; start = 1'b1; end
      if (n == 6) start = 1'b0;
    end
    ref_model(4321, 1'b1, 1'b0, 8'h81, es, eo);
    n_total++; if (dones !== 1) $display("FAIL busy_done_count: got %0d expected 1", dones); else n_pass++;
    n_total++; if (first !== 28) $display("FAIL busy_latency: got %0d expected 28", first); else n_pass++;
    n_total++; if (segs !== es) $display("FAIL busy_segs: got %h expected %h", segs, es); else n_pass++;
  endtask

  task automatic test_reset_mid();
    int dones;
    @(negedge clk);
    bin = 27'd777; dec_mode = 1'b1; blank_lz = 1'b1; dp = 8'h00; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    for (int n = 1; n <= 10; n++) begin
      @(posedge clk);
      @(negedge clk);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    n_total++; if (segs !== {8{8'hFF}}) $display("FAIL midreset_segs: got %h expected %h", segs, {8{8'hFF}}); else n_pass++;
    n_total++; if (ready !== 1'b1) $display("FAIL midreset_ready: got %b expected 1", ready); else n_pass++;
    dones = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (done_tick) dones++;
    end
    n_total++; if (dones !== 0) $display("FAIL midreset_no_done: got %0d expected 0", dones); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int n, lat;
    logic [63:0] es;
    logic eo;
    @(negedge clk);
    bin = 27'h1234; dec_mode = 1'b0; blank_lz = 1'b0; dp = 8'h00; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    n_total++; if (done_tick !== 1'b1) $display("FAIL b2b_first_done: got %b expected 1", done_tick); else n_pass++;
    bin = 27'd98_765_432; dec_mode = 1'b1; blank_lz = 1'b1; dp = 8'h10; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    lat = -1;
    for (n = 1; n <= 100; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (done_tick) begin lat = n; break; end
    end
    ref_model(98765432, 1'b1, 1'b1, 8'h10, es, eo);
    n_total++; if (lat !== 28) $display("FAIL b2b_latency: got %0d expected 28", lat); else n_pass++;
    n_total++; if (segs !== es) $display("FAIL b2b_segs: got %h expected %h", segs, es); else n_pass++;
  endtask

  task automatic test_random();
    int lat, rb;
    logic [W-1:0] v;
    bit dec, blank;
    logic [7:0] dpv;
    logic [63:0] es;
    logic eo;
    for (int k = 0; k < 25; k++) begin
      v = W'($urandom);
      if ($urandom_range(0, 2) == 0) v = W'($urandom_range(0, 999));
      dec = 1'($urandom);
      blank = 1'($urandom);
      dpv = 8'($urandom);
      run_conv(v, dec, blank, dpv, lat, rb);
      ref_model(longint'(v), dec, blank, dpv, es, eo);
      n_total++; if (lat !== (dec ? W + 1 : 1)) $display("FAIL rand%0d_latency: got %0d expected %0d", k, lat, dec ? W + 1 : 1); else n_pass++;
      n_total++; if (segs !== es) $display("FAIL rand%0d_segs v=%0d dec=%0d: got %h expected %h", k, v, dec, segs, es); else n_pass++;
      n_total++; if (overflow !== eo) $display("FAIL rand%0d_ovf: got %b expected %b", k, overflow, eo); else n_pass++;
    end
  endtask

  initial begin
    reset = 1'b1;
    #12;
    reset = 1'b0;
    test_reset();
    test_dec_1234();
    test_hex();
    test_overflow();
    test_dp();
    test_busy_ignore();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
